// File: rtl/keypad_entry.sv
// Scans a 4x4 active-low hex keypad, debounces presses and releases, and shifts
// each accepted hex digit into a 32-bit entry register (newest digit in [3:0]).
module keypad_entry #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  input  logic        clr,
  output logic [3:0]  col,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [31:0] entry,
  output logic [3:0]  digits
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD
  } state_t;

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] div_reg;
  logic [3:0]       col_reg, col_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [1:0]       row_idx_reg, row_idx_next;
  logic [3:0]       pend_code_reg, pend_code_next;
  logic             key_valid_reg, key_valid_next;
  logic [3:0]       key_code_reg, key_code_next;
  logic [31:0]      entry_reg, entry_next;
  logic [3:0]       digits_reg, digits_next;

  logic       tick;
  logic       pressed;
  logic       accept;
  logic [1:0] row_idx_cur;
  logic [1:0] col_idx_cur;
  logic [3:0] col_rot;

  assign tick    = (div_reg == DIV_LAST);
  assign pressed = (row != 4'hF);
  assign col_rot = {col_reg[2:0], col_reg[3]};
  assign cnt_inc = cnt_reg + CNT_W'(1);

  // Several closed rows resolve to the lowest index.
  always_comb begin
    row_idx_cur = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row[i]) row_idx_cur = 2'(i);
    end
    col_idx_cur = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!col_reg[i]) col_idx_cur = 2'(i);
    end
  end

  // Scan / debounce FSM; every decision is taken on a tick only.
  always_comb begin
    state_next     = state_reg;
    col_next       = col_reg;
    cnt_next       = cnt_reg;
    row_idx_next   = row_idx_reg;
    pend_code_next = pend_code_reg;
    accept         = 1'b0;
    if (tick) begin
      case (state_reg)
        ST_SCAN: begin
          if (pressed) begin
            row_idx_next   = row_idx_cur;
            pend_code_next = {row_idx_cur, col_idx_cur};
            if (DEBOUNCE == 1) begin
              accept     = 1'b1;
              cnt_next   = '0;
              state_next = ST_HELD;
            end else begin
              cnt_next   = CNT_W'(1);
              state_next = ST_DEBOUNCE;
            end
          end else begin
            col_next = col_rot;
          end
        end
        ST_DEBOUNCE: begin
          if (pressed && (row_idx_cur == row_idx_reg)) begin
            if (cnt_inc == CNT_DONE) begin
              accept     = 1'b1;
              cnt_next   = '0;
              state_next = ST_HELD;
            end else begin
              cnt_next = cnt_inc;
            end
          end else begin
            cnt_next   = '0;
            col_next   = col_rot;
            state_next = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (!pressed) begin
            if (cnt_inc == CNT_DONE) begin
              cnt_next   = '0;
              col_next   = col_rot;
              state_next = ST_SCAN;
            end else begin
              cnt_next = cnt_inc;
            end
          end else begin
            cnt_next = '0;
          end
        end
        default: begin
          state_next = ST_SCAN;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // clr overrides the shift but leaves the key pulse and code untouched.
  always_comb begin
    key_valid_next = accept;
    key_code_next  = key_code_reg;
    entry_next     = entry_reg;
    digits_next    = digits_reg;
    if (accept) begin
      key_code_next = pend_code_next;
      entry_next    = {entry_reg[27:0], pend_code_next};
      digits_next   = (digits_reg == 4'd8) ? 4'd8 : digits_reg + 4'd1;
    end
    if (clr) begin
      entry_next  = 32'd0;
      digits_next = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_SCAN;
      div_reg       <= '0;
      col_reg       <= 4'b1110;
      cnt_reg       <= '0;
      row_idx_reg   <= 2'd0;
      pend_code_reg <= 4'd0;
      key_valid_reg <= 1'b0;
      key_code_reg  <= 4'd0;
      entry_reg     <= 32'd0;
      digits_reg    <= 4'd0;
    end else begin
      state_reg     <= state_next;
      div_reg       <= tick ? '0 : div_reg + DIV_W'(1);
      col_reg       <= col_next;
      cnt_reg       <= cnt_next;
      row_idx_reg   <= row_idx_next;
      pend_code_reg <= pend_code_next;
      key_valid_reg <= key_valid_next;
      key_code_reg  <= key_code_next;
      entry_reg     <= entry_next;
      digits_reg    <= digits_next;
    end
  end

  assign col       = col_reg;
  assign key_valid = key_valid_reg;
  assign key_code  = key_code_reg;
  assign entry     = entry_reg;
  assign digits    = digits_reg;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a simulated key matrix drives the rows, and a queue-based
// reference model is compared against the DUT on every cycle, plus scripted checks.
module tb_keypad_entry;

  localparam int SD = 4;
  localparam int DB = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [31:0] entry;
  logic [3:0]  digits;
  logic [15:0] keys;

  int tests  = 0;
  int fails  = 0;
  int pulses = 0;

  keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk(clk), .rst(rst), .row(row), .clr(clr), .col(col),
    .key_valid(key_valid), .key_code(key_code), .entry(entry), .digits(digits)
  );

  always #5 clk = ~clk;

  // Key matrix: keys[4*r+c] closed pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_div, m_col, m_mode, m_cnt, m_row;
  logic [3:0] m_pend, m_code;
  bit         m_valid, m_live;
  logic [3:0] m_q[$];

  function automatic int seen_row(input int c);
    for (int r = 0; r < 4; r++) if (keys[4*r+c]) return r;
    return -1;
  endfunction

  function automatic logic [31:0] m_entry();
    logic [31:0] e = 32'd0;
    foreach (m_q[i]) e = {e[27:0], m_q[i]};
    return e;
  endfunction

  always @(posedge clk) begin : model_p
    bit acc;
    int r;
    if (rst) begin
      m_live = 1'b1; m_div = 0; m_col = 0; m_mode = 0; m_cnt = 0; m_row = 0;
      m_pend = 4'd0; m_code = 4'd0; m_valid = 1'b0;
      m_q.delete();
    end else if (m_live) begin
      acc = 1'b0;
      if (m_div == SD - 1) begin
        r = seen_row(m_col);
        if (m_mode == 0) begin
          if (r >= 0) begin
            m_row = r; m_pend = 4'(4*r + m_col); m_cnt = 1; m_mode = 1; acc = (DB == 1);
          end else m_col = (m_col + 1) % 4;
        end else if (m_mode == 1) begin
          if (r == m_row) begin m_cnt++; acc = (m_cnt == DB); end
          else begin m_cnt = 0; m_mode = 0; m_col = (m_col + 1) % 4; end
        end else begin
          if (r < 0) begin
            m_cnt++;
            if (m_cnt == DB) begin m_cnt = 0; m_mode = 0; m_col = (m_col + 1) % 4; end
          end else m_cnt = 0;
        end
        if (acc) begin m_mode = 2; m_cnt = 0; end
      end
      m_div = (m_div + 1) % SD;
      m_valid = acc;
      if (acc) begin
        m_code = m_pend;
        m_q.push_back(m_pend);
        if (m_q.size() > 8) void'(m_q.pop_front());
      end
      if (clr) m_q.delete();
    end
  end

  always @(negedge clk) begin : cmp_p
    logic [3:0] ec;
    if (m_live) begin
      ec = 4'hF;
      ec[m_col] = 1'b0;
      check("col", col, ec);
      check("key_valid", key_valid, m_valid);
      check("key_code", key_code, m_code);
      check("entry", entry, m_entry());
      check("digits", digits, m_q.size());
    end
  end

  always @(negedge clk) if (key_valid === 1'b1) pulses++;

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_col_start(input int c);
    logic [3:0] target, prev;
    int n;
    target = 4'hF; target[c] = 1'b0;
    prev = col; n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (col == target && prev != target) break;
      prev = col;
      if (n > 200) begin check("col_timeout", col, target); break; end
    end
  endtask

  task automatic wait_pulse();
    int n = 0;
    do begin @(negedge clk); n++; end while (key_valid !== 1'b1 && n < 200);
    if (key_valid !== 1'b1) check("pulse_timeout", key_valid, 1);
  endtask

  task automatic enter_key(input int code);
    wait_col_start((code % 4 + 1) % 4);
    step(1);
    keys[code] = 1'b1;
    wait_pulse();
    @(posedge clk); #1;
    keys = 16'd0;
    step(16);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0, hold, nk;
    rst = 1'b1; clr = 1'b0; keys = 16'd0;

    // Reset and idle scan
    step(3);
    check("rst_col", col, 4'b1110);
    check("rst_valid", key_valid, 0);
    check("rst_entry", entry, 0);
    check("rst_digits", digits, 0);
    rst = 1'b0;
    for (int k = 0; k < 32; k++) begin
      logic [3:0] ec;
      ec = 4'hF; ec[(k / 4) % 4] = 1'b0;
      @(negedge clk);
      check("idle_col", col, ec);
      @(posedge clk); #1;
    end

    // Clean press of row1/col2 with latency check
    wait_col_start(1);
    step(1);
    keys[6] = 1'b1;
    wait_col_start(2);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i < 8) check("latency_early", key_valid, 0);
      else       check("latency_pulse", key_valid, 1);
    end
    check("press_code", key_code, 4'h6);
    check("press_entry", entry, 32'h6);
    check("press_digits", digits, 1);
    check("model_code", m_code, 4'h6);
    @(posedge clk); #1;
    p0 = pulses;
    step(100);
    check("held_no_repeat", pulses, p0);
    keys = 16'd0;
    step(16);

    // Single-sample bounce during scan
    p0 = pulses;
    wait_col_start(1);
    step(1);
    keys[9] = 1'b1;
    step(3);
    keys = 16'd0;
    step(4);
    check("bounce_resume_col", col, 4'b1011);
    check("bounce_no_pulse", pulses, p0);

    // Release bounce while held: F, low, F, F
    wait_col_start(0);
    step(1);
    keys[5] = 1'b1;
    wait_pulse();
    @(posedge clk); #1;
    keys = 16'd0; step(4);
    keys[5] = 1'b1; step(4);
    keys = 16'd0; step(4);
    check("held_frozen_col", col, 4'b1101);
    step(4);
    check("held_release_col", col, 4'b1011);
    step(8);

    // Keys 1..9 saturate at 8 digits
    clr = 1'b1; step(1); clr = 1'b0;
    p0 = pulses;
    for (int d = 1; d <= 9; d++) enter_key(d);
    check("sat_entry", entry, 32'h23456789);
    check("sat_digits", digits, 8);
    check("sat_pulses", pulses - p0, 9);
    check("model_sat_entry", m_entry(), 32'h23456789);

    // clr coincident with the accept of key F
    wait_col_start(0);
    step(1);
    keys[15] = 1'b1;
    wait_col_start(3);
    step(7);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    @(negedge clk);
    check("clr_acc_valid", key_valid, 1);
    check("clr_acc_code", key_code, 4'hF);
    check("clr_acc_entry", entry, 0);
    check("clr_acc_digits", digits, 0);
    @(posedge clk); #1;
    keys = 16'd0;
    step(16);
    enter_key(10);
    check("after_clr_entry", entry, 32'hA);
    check("after_clr_digits", digits, 1);

    // Reset during debounce discards the pending press
    wait_col_start(2);
    step(1);
    keys[7] = 1'b1;
    wait_col_start(3);
    step(5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    keys = 16'd0;
    @(negedge clk);
    check("midrst_col", col, 4'b1110);
    check("midrst_valid", key_valid, 0);
    check("midrst_code", key_code, 0);
    check("midrst_entry", entry, 0);
    check("midrst_digits", digits, 0);
    @(posedge clk); #1;
    p0 = pulses;
    step(40);
    check("midrst_no_pulse", pulses, p0);

    // Two rows closed on column 0: lowest row wins
    wait_col_start(1);
    step(1);
    keys[0] = 1'b1; keys[4] = 1'b1;
    wait_pulse();
    check("lowest_row_code", key_code, 4'h0);
    check("lowest_row_digits", digits, 1);
    @(posedge clk); #1;
    keys = 16'd0;
    step(16);

    // Randomized presses, bounces, clears and occasional resets
    for (int it = 0; it < 60; it++) begin
      keys = 16'd0;
      nk = $urandom_range(0, 2);
      repeat (nk) keys[$urandom_range(0, 15)] = 1'b1;
      hold = $urandom_range(1, 40);
      repeat (hold) begin
        clr = ($urandom_range(0, 19) == 0);
        rst = ($urandom_range(0, 299) == 0);
        step(1);
      end
      clr = 1'b0; rst = 1'b0; keys = 16'd0;
      step($urandom_range(0, 20));
    end
    step(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
